bus_control_sequencer: RTL and testbench

Control-step sequencer for the single-bus datapath. It steps fetch and execute micro-operations (T0..T6) and drives the one-hot source-select enables (R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Cout) that the bus mux consumes. It also drives the matching destination load enables. It sits between the instruction register and the datapath, and is the only legal driver of bus source selects.

---
 rtl/cpu_pkg.sv | 86 ++++++++
 rtl/select_encode.sv | 43 ++++
 rtl/bus_control_sequencer.sv | 158 +++++++++++++++
 tb/tb_bus_control_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared ISA constants, IR field positions, control-step state
//                encoding and opcode classification for the bus sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcode constants (IR[31:27])
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // IR field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    // Control steps
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } step_t;

    // Execute-phase behaviour groups
    typedef enum logic [2:0] {
        C_RR     = 3'd0,
        C_IMM    = 3'd1,
        C_UNARY  = 3'd2,
        C_MULDIV = 3'd3,
        C_MFHI   = 3'd4,
        C_MFLO   = 3'd5,
        C_HALT   = 3'd6,
        C_NOP    = 3'd7
    } op_class_t;

    // Undefined opcodes behave exactly like nop
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   cls = C_RR;
            OP_ADDI, OP_ANDI, OP_ORI:         cls = C_IMM;
            OP_NEG, OP_NOT:                   cls = C_UNARY;
            OP_MUL, OP_DIV:                   cls = C_MULDIV;
            OP_MFHI:                          cls = C_MFHI;
            OP_MFLO:                          cls = C_MFLO;
            OP_HALT:                          cls = C_HALT;
            OP_NOP:                           cls = C_NOP;
            default:                          cls = C_NOP;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/select_encode.sv
`default_nettype none
// ============================================================================
//  Module      : select_encode
//  Description : Turns the sequencer's Gra/Grb/Grc field strobes and Rin/Rout
//                direction strobes into one-hot GPR load/source enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module select_encode
    import cpu_pkg::*;
(
    input  logic [31:0] IR,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    output logic [15:0] R_in,
    output logic [15:0] R_out
);

    logic [3:0]  reg_sel;
    logic [15:0] reg_onehot;

    // Opcode and immediate bits play no part in register selection
    logic unused_ir_bits;
    assign unused_ir_bits = ^{IR[OPC_MSB:OPC_LSB], IR[RC_LSB-1:0]};

    // Pick the strobed field and expand it to a single-bit enable
    always_comb begin
        reg_sel = 4'd0;
        if (Gra)
            reg_sel = IR[RA_MSB:RA_LSB];
        else if (Grb)
            reg_sel = IR[RB_MSB:RB_LSB];
        else if (Grc)
            reg_sel = IR[RC_MSB:RC_LSB];
        reg_onehot = 16'd1 << reg_sel;
        R_in       = Rin  ? reg_onehot : 16'd0;
        R_out      = Rout ? reg_onehot : 16'd0;
    end

endmodule
`default_nettype wire

// File: rtl/bus_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_control_sequencer
//  Description : Fetch/execute control-step sequencer (T0..T6) for the
//                single-bus datapath; sole driver of bus source selects and
//                the matching destination load enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    output logic [15:0] R_out,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        In_Portout,
    output logic        Cout,
    output logic [15:0] R_in,
    output logic        HIin,
    output logic        LOin,
    output logic        Zin,
    output logic        Yin,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Read,
    output logic        IncPC,
    output logic [4:0]  alu_op,
    output logic        done,
    output logic        halted
);

    step_t     state;
    step_t     next_state;
    op_class_t op_class;
    logic [4:0] opcode;
    logic gra, grb, grc, gpr_in, gpr_out;

    assign opcode   = IR[OPC_MSB:OPC_LSB];
    assign op_class = classify(opcode);

    // Step register; clear drops straight back to IDLE
    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Moore decode of step and opcode class, plus next-step selection
    always_comb begin
        next_state = state;
        HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        PCout = 1'b0; MDRout = 1'b0; In_Portout = 1'b0; Cout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; Zin = 1'b0; Yin = 1'b0;
        PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Read = 1'b0; IncPC = 1'b0; alu_op = 5'd0;
        done = 1'b0; halted = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; gpr_in = 1'b0; gpr_out = 1'b0;

        case (state)
            S_IDLE: begin
                if (run)
                    next_state = S_T0;
            end
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                next_state = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                case (op_class)
                    C_RR, C_IMM, C_UNARY: begin
                        grb = 1'b1; gpr_out = 1'b1; Yin = 1'b1;
                        next_state = S_T4;
                    end
                    C_MULDIV: begin
                        gra = 1'b1; gpr_out = 1'b1; Yin = 1'b1;
                        next_state = S_T4;
                    end
                    C_MFHI: begin
                        HIout = 1'b1; gra = 1'b1; gpr_in = 1'b1; done = 1'b1;
                    end
                    C_MFLO: begin
                        LOout = 1'b1; gra = 1'b1; gpr_in = 1'b1; done = 1'b1;
                    end
                    C_HALT: begin
                        next_state = S_HALT;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                // mul/div also present their opcode so the ALU knows which
                Zin    = 1'b1;
                alu_op = opcode;
                case (op_class)
                    C_RR:    begin grc = 1'b1; gpr_out = 1'b1; end
                    C_IMM:   begin Cout = 1'b1; end
                    default: begin grb = 1'b1; gpr_out = 1'b1; end
                endcase
                next_state = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (op_class == C_MULDIV) begin
                    LOin = 1'b1;
                    next_state = S_T6;
                end else begin
                    gra = 1'b1; gpr_in = 1'b1; done = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // run is only consulted on the final step of an instruction
        if (done)
            next_state = run ? S_T0 : S_IDLE;
    end

    select_encode u_select_encode (
        .IR    (IR),
        .Gra   (gra),
        .Grb   (grb),
        .Grc   (grc),
        .Rin   (gpr_in),
        .Rout  (gpr_out),
        .R_in  (R_in),
        .R_out (R_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_control_sequencer
//  Description : Self-checking bench: directed scenarios plus randomized
//                instruction streams against a step-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_control_sequencer;

    localparam logic [4:0] T_ADD  = 5'b00000;
    localparam logic [4:0] T_ADDI = 5'b01001;
    localparam logic [4:0] T_MUL  = 5'b01111;
    localparam logic [4:0] T_HALT = 5'b11011;
    localparam logic [4:0] T_UNDF = 5'b10111;

    typedef struct packed {
        logic [15:0] r_out;
        logic hi_o, lo_o, zh_o, zl_o, pc_o, mdr_o, inp_o, c_o;
        logic [15:0] r_in;
        logic hi_i, lo_i, z_i, y_i, pc_i, mar_i, mdr_i, ir_i;
        logic rd, inc;
        logic [4:0] alu;
        logic done, halted;
    } outs_t;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        run = 1'b0;
    logic [31:0] IR = 32'd0;
    logic [15:0] R_out, R_in;
    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Cout;
    logic HIin, LOin, Zin, Yin, PCin, MARin, MDRin, IRin, Read, IncPC;
    logic [4:0] alu_op;
    logic done, halted;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: each instruction is a list of expected step vectors
    outs_t       exp_q[$];
    int          idx = 0;
    int          mode = 0;      // 0 idle, 1 executing, 2 halted
    logic        cur_halt = 1'b0;
    logic [31:0] next_ir = 32'd0;

    bus_control_sequencer dut (
        .clk(clk), .clear(clear), .run(run), .IR(IR),
        .R_out(R_out), .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
        .In_Portout(In_Portout), .Cout(Cout),
        .R_in(R_in), .HIin(HIin), .LOin(LOin), .Zin(Zin), .Yin(Yin),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Read(Read), .IncPC(IncPC), .alu_op(alu_op),
        .done(done), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o = '{r_out: R_out, hi_o: HIout, lo_o: LOout, zh_o: Zhighout, zl_o: Zlowout,
              pc_o: PCout, mdr_o: MDRout, inp_o: In_Portout, c_o: Cout,
              r_in: R_in, hi_i: HIin, lo_i: LOin, z_i: Zin, y_i: Yin, pc_i: PCin,
              mar_i: MARin, mdr_i: MDRin, ir_i: IRin, rd: Read, inc: IncPC,
              alu: alu_op, done: done, halted: halted};
        return o;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] n);
        return 16'd1 << n;
    endfunction

    // Expand an instruction into its expected T0.. step list
    function automatic void build(input logic [31:0] ir);
        outs_t s;
        logic [4:0] op = ir[31:27];
        logic [3:0] ra = ir[26:23];
        logic [3:0] rb = ir[22:19];
        logic [3:0] rc = ir[18:15];
        exp_q.delete();
        cur_halt = 1'b0;
        s = '0; s.pc_o = 1; s.mar_i = 1; s.inc = 1; s.z_i = 1; exp_q.push_back(s);
        s = '0; s.zl_o = 1; s.pc_i = 1; s.rd = 1; s.mdr_i = 1; exp_q.push_back(s);
        s = '0; s.mdr_o = 1; s.ir_i = 1; exp_q.push_back(s);
        if (op <= 5'd8 || op == 5'd9 || op == 5'd10 || op == 5'd11 || op == 5'd17 || op == 5'd18) begin
            s = '0; s.r_out = oh(rb); s.y_i = 1; exp_q.push_back(s);
            s = '0; s.z_i = 1; s.alu = op;
            if (op <= 5'd8)       s.r_out = oh(rc);
            else if (op <= 5'd11) s.c_o = 1;
            else                  s.r_out = oh(rb);
            exp_q.push_back(s);
            s = '0; s.zl_o = 1; s.r_in = oh(ra); s.done = 1; exp_q.push_back(s);
        end else if (op == 5'd15 || op == 5'd16) begin
            s = '0; s.r_out = oh(ra); s.y_i = 1; exp_q.push_back(s);
            s = '0; s.r_out = oh(rb); s.z_i = 1; s.alu = op; exp_q.push_back(s);
            s = '0; s.zl_o = 1; s.lo_i = 1; exp_q.push_back(s);
            s = '0; s.zh_o = 1; s.hi_i = 1; s.done = 1; exp_q.push_back(s);
        end else if (op == 5'd24 || op == 5'd25) begin
            s = '0; s.hi_o = (op == 5'd24); s.lo_o = (op == 5'd25);
            s.r_in = oh(ra); s.done = 1; exp_q.push_back(s);
        end else if (op == 5'd27) begin
            s = '0; exp_q.push_back(s);
            cur_halt = 1'b1;
        end else begin
            s = '0; s.done = 1; exp_q.push_back(s);
        end
    endfunction

    function automatic outs_t expected();
        outs_t e = '0;
        if (mode == 1) e = exp_q[idx];
        else if (mode == 2) e.halted = 1'b1;
        return e;
    endfunction

    task automatic compare_all(input string tag);
        outs_t got = sample();
        logic [23:0] src = {R_out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Cout};
        check(tag, 64'(got), 64'(expected()));
        check({tag, "_src_onehot"}, 64'($countones(src) <= 1), 64'd1);
        check({tag, "_rin_onehot"}, 64'($countones(R_in) <= 1), 64'd1);
    endtask

    // One clock: drive run, advance the model on the edge, check at negedge
    task automatic tick(input logic run_v);
        logic start = 1'b0;
        run = run_v;
        @(posedge clk);
        cyc++;
        if (mode == 0) begin
            start = run_v;
        end else if (mode == 1) begin
            if (exp_q[idx].done) begin
                if (run_v) start = 1'b1;
                else mode = 0;
            end else if (cur_halt && idx == exp_q.size() - 1) begin
                mode = 2;
            end else begin
                idx++;
            end
        end
        if (start) begin
            build(next_ir);
            idx  = 0;
            mode = 1;
        end
        #1;
        if (start) IR = next_ir;
        @(negedge clk);
        compare_all($sformatf("cyc%0d", cyc));
    endtask

    // Asynchronous clear from the negedge; outputs must drop at once
    task automatic pulse_clear();
        clear = 1'b1;
        #1;
        mode = 0;
        compare_all("clear_async");
        @(posedge clk);
        @(negedge clk);
        compare_all("clear_held");
        clear = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] r = $urandom;
        if (r[31:27] == T_HALT) r[31:27] = 5'b11010;
        return r;
    endfunction

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        compare_all("reset");
        clear = 1'b0;
        tick(1'b0);

        // add R3,R1,R2 interrupted by clear in T4, then restarted and completed
        next_ir = mk(T_ADD, 4'd3, 4'd1, 4'd2);
        repeat (5) tick(1'b1);
        check("at_T4", 64'(idx), 64'd4);
        run = 1'b1;
        pulse_clear();
        repeat (6) tick(1'b1);

        // addi R2,R5,-1 directly after add's done step
        next_ir = {T_ADDI, 4'd2, 4'd5, 19'h7FFFF};
        repeat (6) tick(1'b1);

        // mul R6,R7 with run dropped from T4 onward
        next_ir = mk(T_MUL, 4'd6, 4'd7, 4'd0);
        repeat (5) tick(1'b1);
        repeat (4) tick(1'b0);
        check("mul_idle", 64'(mode), 64'd0);

        // Undefined opcode, back-to-back
        next_ir = mk(T_UNDF, 4'd9, 4'd4, 4'd11);
        repeat (9) tick(1'b1);

        // Randomized stream
        repeat (1500) begin
            next_ir = rand_ir();
            tick($urandom_range(0, 3) != 0);
        end

        // halt: reach HALT, hold regardless of run, then clear
        next_ir = mk(T_HALT, 4'd1, 4'd2, 4'd3);
        for (int i = 0; i < 20 && mode != 2; i++) tick(1'b1);
        check("halt_reached", 64'(mode), 64'd2);
        repeat (22) tick($urandom_range(0, 1) != 0);
        run = 1'b0;
        pulse_clear();
        repeat (2) tick(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
